// File: rtl/isa_pkg.sv
// ISA constants shared by the instruction encoder and the control decoder.
package isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b000110;
  localparam logic [4:0] SHAMT_R  = 5'd10;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_MUL = 6'd50;

  typedef enum logic [2:0] {
    SEL_ADD = 3'd0,
    SEL_SUB = 3'd1,
    SEL_AND = 3'd2,
    SEL_OR  = 3'd3,
    SEL_MUL = 3'd4,
    SEL_LW  = 3'd5,
    SEL_SW  = 3'd6,
    SEL_ILL = 3'd7
  } op_e;

  // Build one instruction word; the SEL_ILL result is never stored.
  function automatic logic [31:0] encode(input op_e op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      SEL_ADD: w = {OP_RTYPE, rs, rt, rd, SHAMT_R, FUNCT_ADD};
      SEL_SUB: w = {OP_RTYPE, rs, rt, rd, SHAMT_R, FUNCT_SUB};
      SEL_AND: w = {OP_RTYPE, rs, rt, rd, SHAMT_R, FUNCT_AND};
      SEL_OR:  w = {OP_RTYPE, rs, rt, rd, SHAMT_R, FUNCT_OR};
      SEL_MUL: w = {OP_RTYPE, rs, rt, rd, SHAMT_R, FUNCT_MUL};
      SEL_LW:  w = {OP_LW, rs, rt, imm};
      SEL_SW:  w = {OP_SW, rs, rt, imm};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO; head is presented combinationally, zero when empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into 32-bit words and buffers them
// for a valid/ready consumer; illegal ops are dropped with an err pulse.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] issued
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready reflects occupancy only, never out_ready.
  op_e              op;
  logic [31:0]      word;
  logic             accept, push, pop, full, empty;
  logic [AW:0]      count;
  logic             err_q, err_d;
  logic [CNT_W-1:0] issued_q, issued_d;

  assign op     = op_e'(in_op);
  assign word   = encode(op, in_rs, in_rt, in_rd, in_imm);
  assign accept = in_valid && in_ready;
  assign push   = accept && (op != SEL_ILL);
  assign pop    = out_valid && out_ready;

  instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (word),
    .rdata_o (out_instr),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;

  always_comb begin
    err_d    = accept && (op == SEL_ILL);
    issued_d = issued_q + (pop ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      issued_q <= '0;
    end else begin
      err_q    <= err_d;
      issued_q <= issued_d;
    end
  end

  assign err    = err_q;
  assign issued = issued_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] issued;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .issued    (issued)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
  endtask

  task automatic push_one(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm);
    set_req(op, rs, rt, rd, imm);
    step();
    in_valid = 1'b0;
    in_op    = 3'($urandom_range(0, 7));
    in_imm   = 16'($urandom_range(0, 65535));
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD: no bypass, then visible after the accepting edge
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF);
    chk("add_no_bypass", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_word", out_instr, 32'h10221AA0);
    pop_one();
    chk("add_issued", 32'(issued), 32'd1);
    chk("add_empty", 32'(out_valid), 32'd0);
    chk("add_empty_instr", out_instr, 32'd0);

    push_one(3'd4, 5'd7, 5'd8, 5'd9, 16'h1234);
    chk("mul_word", out_instr, 32'h10E84AB2);
    pop_one();
    push_one(3'd3, 5'd0, 5'd0, 5'd31, 16'hFFFF);
    chk("or_word", out_instr, 32'h1000FAA5);
    pop_one();
    push_one(3'd5, 5'd4, 5'd5, 5'd31, 16'h0010);
    chk("lw_word", out_instr, 32'h14850010);
    pop_one();
    push_one(3'd6, 5'd4, 5'd6, 5'd31, 16'hFFFC);
    chk("sw_word", out_instr, 32'h1886FFFC);
    pop_one();
    chk("issued_5", 32'(issued), 32'd5);

    // Fill with out_ready held low, then drain with a fifth request pending
    exp_q = '{32'h102202A0, 32'h10220AA0, 32'h102212A0, 32'h10221AA0, 32'h102222A2};
    for (int i = 0; i < 4; i++) begin
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      push_one(3'd0, 5'd1, 5'd2, 5'(i), 16'h0);
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    set_req(3'd1, 5'd1, 5'd2, 5'd4, 16'h0);
    step();
    step();
    chk("full_hold_ready", 32'(in_ready), 32'd0);
    chk("full_hold_instr", out_instr, exp_q[0]);
    // Pop while full: the pending request must still wait one cycle
    out_ready = 1'b1;
    step();
    chk("drain0_in_ready", 32'(in_ready), 32'd1);
    chk("drain0_next", out_instr, exp_q[1]);
    w = exp_q.pop_front();
    step();
    in_valid = 1'b0;
    w = exp_q.pop_front();
    chk("drain_after_push", out_instr, exp_q[0]);
    for (int i = 0; i < 8 && out_valid; i++) begin
      w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADDEAD;
      chk("drain_order", out_instr, w);
      step();
    end
    out_ready = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("issued_10", 32'(issued), 32'd10);

    // Illegal op then ADD back-to-back
    set_req(3'd7, 5'd9, 5'd9, 5'd9, 16'h5555);
    step();
    chk("ill_err_pulse", 32'(err), 32'd1);
    chk("ill_no_word", 32'(out_valid), 32'd0);
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    in_valid = 1'b0;
    chk("ill_err_clear", 32'(err), 32'd0);
    chk("ill_add_word", out_instr, 32'h10221AA0);
    pop_one();
    chk("ill_empty", 32'(out_valid), 32'd0);
    chk("issued_11", 32'(issued), 32'd11);

    // Reset with two words buffered
    push_one(3'd0, 5'd1, 5'd1, 5'd1, 16'h0);
    push_one(3'd2, 5'd2, 5'd2, 5'd2, 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_issued", 32'(issued), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    push_one(3'd2, 5'd3, 5'd4, 5'd5, 16'hAAAA);
    chk("post_rst_and", out_instr, 32'h10642AA4);
    pop_one();
    chk("post_rst_issued", 32'(issued), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
